// File: rtl/comp_4_cascade.sv
// One slice of a cascadable unsigned magnitude comparator. The local compare wins
// when the slices differ; when they are equal, the lower stage's verdict passes through.
module comp_4_cascade #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             last_gt,
    input  logic             last_eq,
    input  logic             last_lt,
    input  logic             in_valid,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             cascade_err,
    output logic             gt_q,
    output logic             eq_q,
    output logic             lt_q,
    output logic             err_q,
    output logic             out_valid
);

    logic local_gt;
    logic local_lt;
    logic gt_d;
    logic eq_d;
    logic lt_d;
    logic err_d;

    assign local_gt = (a > b);
    assign local_lt = (a < b);

    // Exactly one of last_* may be set; anything else is a broken chain.
    always_comb begin
        cascade_err = 1'b1;
        case ({last_gt, last_eq, last_lt})
            3'b100, 3'b010, 3'b001: cascade_err = 1'b0;
            default:                cascade_err = 1'b1;
        endcase
    end

    // Priority keeps the result one-hot even for a malformed cascade:
    // local gt, local lt, then last_gt, then last_lt, otherwise eq.
    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (local_gt) begin
            gt = 1'b1;
        end else if (local_lt) begin
            lt = 1'b1;
        end else if (last_gt) begin
            gt = 1'b1;
        end else if (last_lt) begin
            lt = 1'b1;
        end else begin
            eq = 1'b1;
        end
    end

    // in_valid qualifies the inputs for one capture; there is no ready, so the
    // result appears one cycle later with out_valid and holds until the next capture.
    always_comb begin
        gt_d  = gt_q;
        eq_d  = eq_q;
        lt_d  = lt_q;
        err_d = err_q;
        if (in_valid) begin
            gt_d  = gt;
            eq_d  = eq;
            lt_d  = lt;
            err_d = cascade_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            err_q     <= err_d;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_comp_4_cascade.sv
// Directed bench for comp_4_cascade: vector table for the combinational verdict,
// hand-written sequences for reset, capture and hold of the registered copy.
module tb_comp_4_cascade;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] last;   // {last_gt, last_eq, last_lt}
        logic [3:0] exp;    // {gt, eq, lt, cascade_err}
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       last_gt;
    logic       last_eq;
    logic       last_lt;
    logic       in_valid;
    logic       gt;
    logic       eq;
    logic       lt;
    logic       cascade_err;
    logic       gt_q;
    logic       eq_q;
    logic       lt_q;
    logic       err_q;
    logic       out_valid;

    int total;
    int bad;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    logic [3:0] held;

    comp_4_cascade #(.WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b),
        .last_gt(last_gt),
        .last_eq(last_eq),
        .last_lt(last_lt),
        .in_valid(in_valid),
        .gt(gt),
        .eq(eq),
        .lt(lt),
        .cascade_err(cascade_err),
        .gt_q(gt_q),
        .eq_q(eq_q),
        .lt_q(lt_q),
        .err_q(err_q),
        .out_valid(out_valid)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic add_vec(input logic [3:0] va, input logic [3:0] vb,
                           input logic [2:0] vl, input logic [3:0] ve);
        vec_t v;
        v.a = va;
        v.b = vb;
        v.last = vl;
        v.exp = ve;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                         input logic [2:0] vl, input logic vv);
        a = va;
        b = vb;
        {last_gt, last_eq, last_lt} = vl;
        in_valid = vv;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        held = 4'b0000;

        //      a      b      {g,e,l}  {gt,eq,lt,err}
        add_vec(4'h2, 4'h4, 3'b010, 4'b0010);
        add_vec(4'h4, 4'h2, 3'b010, 4'b1000);
        add_vec(4'h3, 4'h3, 3'b100, 4'b1000);
        add_vec(4'h3, 4'h3, 3'b001, 4'b0010);
        add_vec(4'h3, 4'h3, 3'b010, 4'b0100);
        add_vec(4'h1, 4'h2, 3'b100, 4'b0010);
        add_vec(4'h5, 4'h3, 3'b100, 4'b1000);
        add_vec(4'hF, 4'h0, 3'b001, 4'b1000);
        add_vec(4'h0, 4'hF, 3'b100, 4'b0010);
        add_vec(4'hA, 4'hA, 3'b000, 4'b0101);
        add_vec(4'hA, 4'hA, 3'b110, 4'b1001);
        add_vec(4'hA, 4'hA, 3'b011, 4'b0011);
        add_vec(4'hA, 4'hA, 3'b101, 4'b1001);
        add_vec(4'hA, 4'hA, 3'b111, 4'b1001);
        add_vec(4'h0, 4'h0, 3'b010, 4'b0100);
        add_vec(4'hF, 4'hF, 3'b001, 4'b0010);
        add_vec(4'hF, 4'hF, 3'b100, 4'b1000);
        add_vec(4'h7, 4'h8, 3'b010, 4'b0010);
        add_vec(4'h8, 4'h7, 3'b010, 4'b1000);
        add_vec(4'h2, 4'h4, 3'b110, 4'b0011);
        add_vec(4'h4, 4'h2, 3'b000, 4'b1001);
        add_vec(4'h0, 4'h0, 3'b000, 4'b0101);

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 3'b010, 1'b0);
        #12;
        check("reset_state", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b00000);

        // Combinational table, applied while still in reset: reset must not matter
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].last, 1'b0);
            #1;
            check($sformatf("comb_vec%0d", i), {1'b0, gt, eq, lt, cascade_err},
                  {1'b0, vecs[i].exp});
        end
        check("reset_held", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b00000);

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h4, 4'h2, 3'b010, 1'b0);
        @(posedge clk); #1;
        check("idle_after_reset", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b00000);

        // Single capture then hold
        @(negedge clk);
        drive(4'h4, 4'h2, 3'b010, 1'b1);
        @(posedge clk); #1;
        check("capture_gt", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b11000);
        @(negedge clk);
        drive(4'h1, 4'h2, 3'b010, 1'b0);
        #1;
        check("comb_after_change", {1'b0, gt, eq, lt, cascade_err}, 5'b00010);
        @(posedge clk); #1;
        check("hold_gt", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b01000);

        // Reset mid-clock discards the pending capture, asynchronously
        @(negedge clk);
        drive(4'hA, 4'hA, 3'b000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b00000);
        check("comb_in_reset", {1'b0, gt, eq, lt, cascade_err}, 5'b00101);
        @(posedge clk); #1;
        check("reset_blocks_edge", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hA, 4'hA, 3'b000, 1'b0);
        @(posedge clk); #1;
        check("pending_discarded", {out_valid, gt_q, eq_q, lt_q, err_q}, 5'b00000);

        // Back-to-back captures with gaps; scoreboard tracks expected registered output
        held = 4'b0000;
        for (int i = 0; i < vecs.size(); i++) begin
            logic v;
            v = (i % 3 != 2);
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].last, v);
            if (v) held = vecs[i].exp;
            exp_q.push_back({v, held});
            @(posedge clk); #1;
            check($sformatf("reg_vec%0d", i), {out_valid, gt_q, eq_q, lt_q, err_q},
                  exp_q.pop_front());
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("final_idle", {out_valid, gt_q, eq_q, lt_q, err_q}, {1'b0, held});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
